fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction fetch and execution sequencer that sits directly upstream of the instruction decoder.
- Holds the program counter, fetches 32-bit instruction words from the flat RAM vector into the instruction register, and steps the state machine IF -> ID -> IE.
- Generates the one-hot micro-step counter that the decoder uses to sequence multi-cycle instructions.
- Reacts to the decoder's end/jump/halt strobes and its condition result.

Parameters:
RAM_SIZE, 256, number of 32-bit words in the ram vector; word n occupies bits [n*32+31 : n*32]

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
ram  input  RAM_SIZE*32  flat program memory, word-addressed by pc
inst_condition  input  1  decoder's condition result for current ir; sampled only in ID
end_inst  input  1  decoder strobe: current instruction finishes this cycle; sampled only in IE
jmp_inst  input  1  with end_inst: load pc from jmp_address instead of pc+1
hlt_inst  input  1  decoder strobe: enter halt; sampled only in IE
jmp_address  input  8  jump target word address
ir  output  32  instruction register
clks  output  16  one-hot micro-step: CLK_0=16'h0001 ... CLK_F=16'h8000
pc  output  8  program counter (word address)
state  output  2  IF=2'd0, ID=2'd1, IE=2'd2, HLT=2'd3; names/values exported as localparams IF, ID, IE, HLT, CLK_0..CLK_F

Behaviour:
Reset:
- Reset (posedge clk with reset=1) overrides everything, including mid-instruction and HLT.
- Reset values: pc=0, ir=0, state=IF, clks=CLK_0.

IF (1 cycle):
- ir <= ram word[pc]; state <= ID; clks <= CLK_0.
- If pc >= RAM_SIZE: ir <= 32'h0 (NOP encoding); no out-of-range slice.

ID (1 cycle):
- The decoder computes inst_condition combinationally from ir.
- inst_condition=1: state <= IE, clks <= CLK_0.
- inst_condition=0: instruction skipped; pc <= pc+1; state <= IF.

IE, evaluated each cycle in priority order:
1. hlt_inst=1: state <= HLT; pc, ir, clks hold.
2. end_inst=1: pc <= jmp_inst ? jmp_address : pc+1; state <= IF; clks <= CLK_0.
3. clks==CLK_F and end_inst=0: micro-step timeout; treated as end_inst with jmp_inst=0 (pc <= pc+1, state <= IF, clks <= CLK_0).
4. Otherwise: clks <= clks<<1; stay in IE.

Strobe qualification:
- jmp_inst without end_inst is ignored.
- end_inst, jmp_inst and hlt_inst are ignored outside IE.
- inst_condition is ignored outside ID.

HLT:
- Terminal state; all outputs hold until reset.

Arithmetic and timing:
- pc+1 is 8-bit and wraps 255 -> 0.
- jmp_address is used unmodified; no RAM_SIZE check at jump time (the IF out-of-range rule covers it).
- clks is always exactly one-hot; it is CLK_0 in IF and ID.
- Minimum instruction latency: 3 cycles (IF, ID, IE with end_inst at CLK_0).
- Skipped instruction: 2 cycles.
- An instruction ending at CLK_n takes 3+n cycles.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, ram words 0..3 = 0, inst_condition=1, end_inst held 1 -> state cycles 0,1,2,0,... per instruction; pc 0->1->2->3, each increment 3 cycles apart; ir=0.
2. ram[0]=32'h0804_0005, inst_condition=0 -> ir=32'h0804_0005 after IF; state never reaches IE; pc=1 two cycles after IF.
3. In IE at pc=5, end_inst=1, jmp_inst=1, jmp_address=8'h40 -> next state IF, pc=8'h40, next ir=ram word 64. Separately, jmp_inst=1 with end_inst=0 -> pc unchanged, clks=16'h0002.
4. end_inst asserted only when clks==16'h0800 (MUL-style) -> clks walks 0001,0002,...,0800 over 12 IE cycles; then IF with pc+1. With end_inst never asserted -> after clks=16'h8000 the next state is IF and pc increments (timeout).
5. hlt_inst=1 in IE at pc=7 -> state=3, pc=7 and ir/clks frozen for 100 cycles despite toggling end_inst/jmp_inst; reset=1 for one cycle -> pc=0, state=0, clks=16'h0001, ir=0.
6. pc=255 with end_inst (no jmp) -> pc=0. With RAM_SIZE=16, jump to 8'h20 -> ir=32'h0 after IF. Reset asserted mid-IE at clks=16'h0010 -> all reset values on the next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: owns pc and ir, steps IF -> ID -> IE,
// and drives the one-hot micro-step counter consumed by the decoder.
module fetch_sequencer #(
    parameter int RAM_SIZE = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [RAM_SIZE*32-1:0]  ram,
    input  logic                    inst_condition,
    input  logic                    end_inst,
    input  logic                    jmp_inst,
    input  logic                    hlt_inst,
    input  logic [7:0]              jmp_address,
    output logic [31:0]             ir,
    output logic [15:0]             clks,
    output logic [7:0]              pc,
    output logic [1:0]              state
);
    localparam logic [1:0] IF  = 2'd0;
    localparam logic [1:0] ID  = 2'd1;
    localparam logic [1:0] IE  = 2'd2;
    localparam logic [1:0] HLT = 2'd3;

    localparam logic [15:0] CLK_0 = 16'h0001;
    localparam logic [15:0] CLK_1 = 16'h0002;
    localparam logic [15:0] CLK_2 = 16'h0004;
    localparam logic [15:0] CLK_3 = 16'h0008;
    localparam logic [15:0] CLK_4 = 16'h0010;
    localparam logic [15:0] CLK_5 = 16'h0020;
    localparam logic [15:0] CLK_6 = 16'h0040;
    localparam logic [15:0] CLK_7 = 16'h0080;
    localparam logic [15:0] CLK_8 = 16'h0100;
    localparam logic [15:0] CLK_9 = 16'h0200;
    localparam logic [15:0] CLK_A = 16'h0400;
    localparam logic [15:0] CLK_B = 16'h0800;
    localparam logic [15:0] CLK_C = 16'h1000;
    localparam logic [15:0] CLK_D = 16'h2000;
    localparam logic [15:0] CLK_E = 16'h4000;
    localparam logic [15:0] CLK_F = 16'h8000;

    typedef enum logic [1:0] {
        ST_IF  = IF,
        ST_ID  = ID,
        ST_IE  = IE,
        ST_HLT = HLT
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [31:0] ir_reg, ir_next;
    logic [15:0] clks_reg, clks_next;
    logic [15:0] clks_adv;
    logic [31:0] fetch_word;
    logic [7:0]  pc_inc;

    logic [31:0] ram_words [RAM_SIZE];

    for (genvar gi = 0; gi < RAM_SIZE; gi++) begin : g_unpack
        assign ram_words[gi] = ram[gi*32 +: 32];
    end

    // Addresses past the end of memory fall through the loop and read as NOP (0).
    always_comb begin
        fetch_word = 32'h0;
        for (int i = 0; i < RAM_SIZE; i++) begin
            if ({24'd0, pc_reg} == i[31:0]) begin
                fetch_word = ram_words[i];
            end
        end
    end

    assign pc_inc = pc_reg + 8'd1;

    // Explicit step table; any non-one-hot value recovers to CLK_0.
    always_comb begin
        clks_adv = CLK_0;
        case (clks_reg)
            CLK_0:   clks_adv = CLK_1;
            CLK_1:   clks_adv = CLK_2;
            CLK_2:   clks_adv = CLK_3;
            CLK_3:   clks_adv = CLK_4;
            CLK_4:   clks_adv = CLK_5;
            CLK_5:   clks_adv = CLK_6;
            CLK_6:   clks_adv = CLK_7;
            CLK_7:   clks_adv = CLK_8;
            CLK_8:   clks_adv = CLK_9;
            CLK_9:   clks_adv = CLK_A;
            CLK_A:   clks_adv = CLK_B;
            CLK_B:   clks_adv = CLK_C;
            CLK_C:   clks_adv = CLK_D;
            CLK_D:   clks_adv = CLK_E;
            CLK_E:   clks_adv = CLK_F;
            default: clks_adv = CLK_0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        clks_next  = clks_reg;
        case (state_reg)
            ST_IF: begin
                ir_next    = fetch_word;
                state_next = ST_ID;
                clks_next  = CLK_0;
            end
            ST_ID: begin
                clks_next = CLK_0;
                if (inst_condition) begin
                    state_next = ST_IE;
                end else begin
                    pc_next    = pc_inc;
                    state_next = ST_IF;
                end
            end
            ST_IE: begin
                if (hlt_inst) begin
                    state_next = ST_HLT;
                end else if (end_inst) begin
                    pc_next    = jmp_inst ? jmp_address : pc_inc;
                    state_next = ST_IF;
                    clks_next  = CLK_0;
                end else if (clks_reg == CLK_F) begin
                    // Micro-step timeout behaves like a plain end of instruction.
                    pc_next    = pc_inc;
                    state_next = ST_IF;
                    clks_next  = CLK_0;
                end else begin
                    clks_next = clks_adv;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IF;
            pc_reg    <= 8'd0;
            ir_reg    <= 32'h0;
            clks_reg  <= CLK_0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            clks_reg  <= clks_next;
        end
    end

    assign ir    = ir_reg;
    assign clks  = clks_reg;
    assign pc    = pc_reg;
    assign state = state_reg;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed plan steps then random traffic, both
// checked cycle by cycle against a behavioural model of the sequencing rules.
`timescale 1ns/1ps
module tb_fetch_sequencer;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [256*32-1:0] ram;
    logic              inst_condition = 1'b0;
    logic              end_inst = 1'b0;
    logic              jmp_inst = 1'b0;
    logic              hlt_inst = 1'b0;
    logic [7:0]        jmp_address = 8'd0;
    logic [31:0]       ir, ir16;
    logic [15:0]       clks, clks16;
    logic [7:0]        pc, pc16;
    logic [1:0]        state, state16;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Model: phase 0=fetch,1=decode,2=execute,3=halted; step n means micro-step n.
    int          m_phase = 0;
    int          m_pc = 0;
    int          m_step = 0;
    logic [31:0] m_ir = 32'h0;
    logic [31:0] m_ir16 = 32'h0;

    fetch_sequencer #(.RAM_SIZE(256)) dut (
        .clk(clk), .reset(reset), .ram(ram), .inst_condition(inst_condition),
        .end_inst(end_inst), .jmp_inst(jmp_inst), .hlt_inst(hlt_inst),
        .jmp_address(jmp_address), .ir(ir), .clks(clks), .pc(pc), .state(state)
    );

    fetch_sequencer #(.RAM_SIZE(16)) dut16 (
        .clk(clk), .reset(reset), .ram(ram[16*32-1:0]), .inst_condition(inst_condition),
        .end_inst(end_inst), .jmp_inst(jmp_inst), .hlt_inst(hlt_inst),
        .jmp_address(jmp_address), .ir(ir16), .clks(clks16), .pc(pc16), .state(state16)
    );

    always #5 clk = ~clk;

    task automatic model_tick();
        if (reset) begin
            m_phase = 0; m_pc = 0; m_step = 0; m_ir = 32'h0; m_ir16 = 32'h0;
        end else begin
            case (m_phase)
                0: begin
                    m_ir   = ram[m_pc*32 +: 32];
                    m_ir16 = (m_pc < 16) ? ram[m_pc*32 +: 32] : 32'h0;
                    m_phase = 1;
                    m_step  = 0;
                end
                1: begin
                    if (inst_condition) m_phase = 2;
                    else begin m_pc = (m_pc + 1) % 256; m_phase = 0; end
                    m_step = 0;
                end
                2: begin
                    if (hlt_inst) m_phase = 3;
                    else if (end_inst || m_step == 15) begin
                        m_pc = (end_inst && jmp_inst) ? int'(jmp_address) : (m_pc + 1) % 256;
                        m_phase = 0;
                        m_step  = 0;
                    end else m_step = m_step + 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] exp_clks;
        exp_clks = 16'h1 << m_step;
        check_val("state", {30'd0, state}, m_phase);
        check_val("pc", {24'd0, pc}, m_pc);
        check_val("clks", {16'd0, clks}, {16'd0, exp_clks});
        check_val("ir", ir, m_ir);
        check_val("ir16", ir16, m_ir16);
        check_val("pc16", {24'd0, pc16}, m_pc);
        check_val("clks16", {16'd0, clks16}, {16'd0, exp_clks});
        check_val("state16", {30'd0, state16}, m_phase);
    endtask

    task automatic cyc(input logic r, input logic c, input logic e, input logic j,
                       input logic h, input logic [7:0] a);
        reset = r; inst_condition = c; end_inst = e; jmp_inst = j; hlt_inst = h; jmp_address = a;
        @(posedge clk);
        model_tick();
        #1;
        cycle++;
        check_all();
    endtask

    // Runs one full instruction from fetch that ends with a jump.
    task automatic jump_to(input logic [7:0] a);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, a);
        $display("txn jump_to %02h pc=%02h state=%0d", a, pc, state);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_pc"}, {24'd0, pc}, 32'd0);
        check_val({tag, "_state"}, {30'd0, state}, 32'd0);
        check_val({tag, "_clks"}, {16'd0, clks}, 32'h1);
        check_val({tag, "_ir"}, ir, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++) ram[i*32 +: 32] = 32'h0;

        cyc(1, 0, 0, 0, 0, 0);
        check_reset_values("reset");
        $display("txn reset pc=%02h state=%0d clks=%04h", pc, state, clks);

        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0, 0);
        check_val("seq_pc3", {24'd0, pc}, 32'd3);
        $display("txn three_min_latency_instructions pc=%02h", pc);

        ram[31:0] = 32'h0804_0005;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check_val("skip_ir", ir, 32'h0804_0005);
        cyc(0, 0, 0, 0, 0, 0);
        check_val("skip_pc", {24'd0, pc}, 32'd1);
        check_val("skip_state", {30'd0, state}, 32'd0);
        $display("txn skipped_instruction pc=%02h ir=%08h", pc, ir);

        cyc(1, 0, 0, 0, 0, 0);
        jump_to(8'd5);
        jump_to(8'h40);
        check_val("jmp_pc", {24'd0, pc}, 32'h40);
        cyc(0, 0, 0, 0, 0, 0);
        check_val("jmp_ir", ir, ram[64*32 +: 32]);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 8'h99);
        check_val("jmp_noend_clks", {16'd0, clks}, 32'h2);
        check_val("jmp_noend_pc", {24'd0, pc}, 32'h40);
        cyc(0, 0, 1, 0, 0, 0);
        $display("txn jump_and_ignored_jmp pc=%02h", pc);

        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) cyc(0, 0, k == 11, 0, 0, 0);
        check_val("mul_pc", {24'd0, pc}, 32'h42);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) cyc(0, 0, 0, 0, 0, 0);
        check_val("timeout_pc", {24'd0, pc}, 32'h43);
        check_val("timeout_state", {30'd0, state}, 32'd0);
        $display("txn multicycle_and_timeout pc=%02h", pc);

        jump_to(8'd7);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 100; k++)
            cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        check_val("hlt_state", {30'd0, state}, 32'd3);
        check_val("hlt_pc", {24'd0, pc}, 32'd7);
        cyc(1, 0, 0, 0, 0, 0);
        check_reset_values("hlt_reset");
        $display("txn halt_then_reset pc=%02h state=%0d", pc, state);

        jump_to(8'hff);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check_val("wrap_pc", {24'd0, pc}, 32'd0);
        jump_to(8'h20);
        cyc(0, 0, 0, 0, 0, 0);
        check_val("oob_ir16", ir16, 32'h0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 0);
        check_val("mid_ie_clks", {16'd0, clks}, 32'h10);
        cyc(1, 0, 1, 1, 1, 8'h55);
        check_reset_values("mid_ie_reset");
        $display("txn wrap_oob_midreset pc=%02h state=%0d", pc, state);

        for (int k = 0; k < 600; k++) begin
            logic r;
            r = ($urandom_range(0, 63) == 0) || (m_phase == 3 && $urandom_range(0, 7) == 0);
            cyc(r, 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                ($urandom_range(0, 47) == 0),
                ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom));
        end
        $display("txn random_traffic cycles=600 pc=%02h state=%0d", pc, state);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
